mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit for the pipelined MIPS core. It is the responder side of the M-stage memory controls: memtoregM (load), memwriteM (store) and ls_ctrlM (access size).
- Converts each M-stage access into a word-wide request/acknowledge bus transaction with byte enables, and returns sign-extended load data.
- Holds the pipeline with stallM until the access completes; flags misaligned accesses and bus timeouts.

---
 rtl/mem_stage_lsu.sv | 155 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit. Turns one pipeline memory access into
// a req/ack word bus transaction, steers store lanes, sign-extends load data,
// and stalls the pipeline until the access completes, is misaligned or times out.
module mem_stage_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memtoregM,
    input  logic        memwriteM,
    input  logic [1:0]  ls_ctrlM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        misalignM,
    output logic        buserrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we, r_load, r_err, r_byte, r_half;
    logic [1:0]  r_lane;

    logic        w_access, w_is_byte, w_is_half, w_is_word, w_misalign, w_start, w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_fmt;
    logic [7:0]  w_b;
    logic [15:0] w_h;

    assign w_is_half  = (ls_ctrlM == 2'b01);
    assign w_is_byte  = (ls_ctrlM == 2'b10);
    assign w_is_word  = !(w_is_half || w_is_byte);   // 00 and 11 both act as word
    assign w_access   = memtoregM | memwriteM;
    assign w_misalign = w_access & ((w_is_half & aluoutM[0]) | (w_is_word & (|aluoutM[1:0])));
    assign w_start    = (r_state == IDLE) & w_access & ~w_misalign;
    assign w_tmo      = (r_cnt == 8'(TIMEOUT - 1));

    // Store lane steering; reads always fetch the whole word
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = writedataM;
        if (w_is_byte) begin
            w_be    = 4'b0001 << aluoutM[1:0];
            w_wdata = {4{writedataM[7:0]}};
        end else if (w_is_half) begin
            w_be    = aluoutM[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{writedataM[15:0]}};
        end
        if (!memwriteM) w_be = 4'b1111;
    end

    // Load formatting: pick the addressed lane from the captured word and sign-extend
    always_comb begin
        w_b = r_rdata[7:0];
        case (r_lane)
            2'd1:    w_b = r_rdata[15:8];
            2'd2:    w_b = r_rdata[23:16];
            2'd3:    w_b = r_rdata[31:24];
            default: w_b = r_rdata[7:0];
        endcase
        w_h = r_lane[1] ? r_rdata[31:16] : r_rdata[15:0];
        if (r_byte)      w_fmt = {{24{w_b[7]}}, w_b};
        else if (r_half) w_fmt = {{16{w_h[15]}}, w_h};
        else             w_fmt = r_rdata;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // FSM next state; ack wins over a coincident timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = REQ;
            REQ:     if (mem_ack || w_tmo) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latch, timeout counter, read capture and error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_load  <= 1'b0;
            r_err   <= 1'b0;
            r_byte  <= 1'b0;
            r_half  <= 1'b0;
            r_lane  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_we    <= memwriteM;
                    r_load  <= memtoregM & ~memwriteM;   // store wins when both set
                    r_addr  <= {aluoutM[31:2], 2'b00};
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                    r_byte  <= w_is_byte;
                    r_half  <= w_is_half;
                    r_lane  <= aluoutM[1:0];
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                end
                REQ: begin
                    if (mem_ack) begin
                        r_rdata <= mem_rdata;
                        r_cnt   <= '0;
                    end else if (w_tmo) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                DONE:    r_err <= 1'b0;
                default: ;
            endcase
        end
    end

    // Outputs; input-derived terms are gated so everything is 0 during reset
    always_comb begin
        stallM    = reset & (w_start | (r_state == REQ));
        misalignM = reset & (r_state == IDLE) & w_misalign;
        buserrM   = (r_state == DONE) & r_err;
        readdataM = ((r_state == DONE) && r_load) ? w_fmt : 32'd0;
        mem_req   = (r_state == REQ);
        mem_we    = (r_state == REQ) & r_we;
        mem_addr  = r_addr;
        mem_be    = r_be;
        mem_wdata = r_wdata;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed stimulus pushes expected bus/response records into
// a queue; a negedge monitor pops and compares whenever the DUT shows activity.
module tb_mem_stage_lsu;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        memtoregM, memwriteM;
    logic [1:0]  ls_ctrlM;
    logic [31:0] aluoutM, writedataM, readdataM;
    logic        stallM, misalignM, buserrM;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    mem_stage_lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .memtoregM(memtoregM), .memwriteM(memwriteM), .ls_ctrlM(ls_ctrlM),
        .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM),
        .stallM(stallM), .misalignM(misalignM), .buserrM(buserrM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mis;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   have_cur = 0;
    int   stall_n = 0, req_n = 0;
    int   total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_ctl", {23'd0, stallM, misalignM, buserrM, mem_req, mem_we, mem_be}, 32'd0);
            chk("rst_data", readdataM | mem_addr | mem_wdata, 32'd0);
            have_cur = 0; stall_n = 0; req_n = 0;
        end else begin
            if (stallM) stall_n++;
            if (misalignM) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mis_unexp: misalignM=1 want no event t=%0t", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("mis_kind", {31'd0, e.mis}, 32'd1);
                    chk("mis_req", {31'd0, mem_req}, 32'd0);
                    chk("mis_stall", {31'd0, stallM}, 32'd0);
                end
            end
            if (mem_req) begin
                if (!have_cur) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL req_unexp: mem_req=1 want no request t=%0t", $time);
                    end else begin
                        cur = q.pop_front();
                        have_cur = 1;
                        chk("req_kind", {31'd0, cur.mis}, 32'd0);
                    end
                end
                if (have_cur) begin
                    req_n++;
                    chk("req_we", {31'd0, mem_we}, {31'd0, cur.we});
                    chk("req_addr", mem_addr, cur.addr);
                    chk("req_be", {28'd0, mem_be}, {28'd0, cur.be});
                    chk("req_wdata", mem_wdata, cur.wdata);
                    chk("req_stall", {31'd0, stallM}, 32'd1);
                end
            end else if (have_cur) begin
                chk("done_rdata", readdataM, cur.rdata);
                chk("done_buserr", {31'd0, buserrM}, {31'd0, cur.err});
                chk("done_stall", {31'd0, stallM}, 32'd0);
                chk("stall_cycles", stall_n, cur.stalls);
                chk("req_cycles", req_n, cur.reqs);
                have_cur = 0; stall_n = 0; req_n = 0;
            end
        end
    end

    task automatic clr();
        memtoregM = 0; memwriteM = 0; ls_ctrlM = 2'b00; aluoutM = 0; writedataM = 0;
    endtask

    // Aligned access; waits<0 means never acknowledge. Called at posedge+1 in IDLE.
    task automatic run(input logic ld, input logic st, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int waits, input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] erd, input logic eerr);
        exp_t e;
        e.mis = 0; e.we = st; e.addr = {a[31:2], 2'b00}; e.be = ebe; e.wdata = ewd;
        e.rdata = erd; e.err = eerr;
        e.reqs = (waits < 0) ? TMO : waits + 1;
        e.stalls = e.reqs + 1;
        q.push_back(e);
        memtoregM = ld; memwriteM = st; ls_ctrlM = sz; aluoutM = a; writedataM = wd;
        mem_rdata = rd;
        @(posedge clk); #1;
        if (waits < 0) begin
            repeat (TMO) begin @(posedge clk); #1; end
        end else begin
            repeat (waits) begin @(posedge clk); #1; end
            mem_ack = 1;
            @(posedge clk); #1;
            mem_ack = 0;
        end
        @(posedge clk); #1;
        clr();
    endtask

    task automatic mis(input logic ld, input logic st, input logic [1:0] sz, input logic [31:0] a);
        exp_t e;
        e.mis = 1; e.we = 0; e.addr = 0; e.be = 0; e.wdata = 0; e.rdata = 0; e.err = 0;
        e.stalls = 0; e.reqs = 0;
        q.push_back(e);
        memtoregM = ld; memwriteM = st; ls_ctrlM = sz; aluoutM = a; writedataM = 32'hFFFF_FFFF;
        mem_ack = 1;                      // stray ack outside REQ must be ignored
        @(posedge clk); #1;
        mem_ack = 0;
        clr();
    endtask

    initial begin
        reset = 0; mem_ack = 0; mem_rdata = 0;
        clr();
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;

        //   ld st  sz     addr         wdata         rdata         w  be       exp wdata     exp rdata     err
        run(1, 0, 2'b00, 32'h100, 32'h0,        32'hDEADBEEF,  0, 4'hF, 32'h0,        32'hDEADBEEF, 0);
        run(1, 0, 2'b10, 32'h203, 32'h0,        32'h80112233,  3, 4'hF, 32'h0,        32'hFFFFFF80, 0);
        run(0, 1, 2'b01, 32'h32,  32'h0000ABCD, 32'h12345678,  1, 4'hC, 32'hABCDABCD, 32'h0,        0);
        mis(1, 0, 2'b00, 32'h41);
        run(1, 0, 2'b01, 32'h102, 32'h0,        32'h80017FFF,  0, 4'hF, 32'h0,        32'hFFFF8001, 0);
        run(1, 0, 2'b10, 32'h1,   32'h0,        32'h000055AA,  2, 4'hF, 32'h0,        32'h00000055, 0);
        run(0, 1, 2'b10, 32'h5,   32'h00000012, 32'h0,         0, 4'h2, 32'h12121212, 32'h0,        0);
        run(1, 1, 2'b00, 32'h8,   32'hCAFEF00D, 32'h11111111,  0, 4'hF, 32'hCAFEF00D, 32'h0,        0);
        mis(0, 1, 2'b01, 32'h3);
        mis(1, 0, 2'b11, 32'h2);

        // Idle cycles with a stray ack: no request may appear
        mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        mem_ack = 0;
        @(posedge clk); #1;

        run(1, 0, 2'b00, 32'h400, 32'h0,        32'hFFFFFFFF, -1, 4'hF, 32'h0,        32'h0,        1);
        run(1, 0, 2'b01, 32'h106, 32'h0,        32'h7FFF0000,  0, 4'hF, 32'h0,        32'h00007FFF, 0);

        // Reset in the middle of REQ: request and stall must drop at once
        begin
            exp_t e;
            e.mis = 0; e.we = 0; e.addr = 32'h10; e.be = 4'hF; e.wdata = 0; e.rdata = 0;
            e.err = 0; e.stalls = 0; e.reqs = 0;
            q.push_back(e);
        end
        memtoregM = 1; ls_ctrlM = 2'b10; aluoutM = 32'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #2 reset = 0;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, stallM}, 32'd0);
        clr();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;

        run(0, 1, 2'b10, 32'h7,   32'h0000005A, 32'h0,         0, 4'h8, 32'h5A5A5A5A, 32'h0,        0);

        repeat (3) @(posedge clk);
        #1;
        chk("q_empty", q.size(), 32'd0);
        chk("no_open_txn", {31'd0, have_cur}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, want finish");
        $fatal(1);
    end

endmodule
